// File: rtl/beam_gate_gen.sv
// beam_gate_gen: multi-channel trigger -> delay -> gate generator with shared run-time config
// Ports: clk, reset (sync, active-high); trig[NUM_CH] per-channel trigger;
//   cfg_load/len_cfg/dly_cfg load the shared gate length and delay registers;
//   gate_out[NUM_CH] registered gate, busy[NUM_CH] channel not idle,
//   done[NUM_CH] one-cycle pulse on return to idle.
// Optional macro BEAM_GATE_RETRIG_EN: a trigger while the gate is active reloads the length.
module beam_gate_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 9,
  parameter int DEFAULT_LEN = 65,
  parameter int DEFAULT_DLY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  len_cfg,
  input  logic [CNT_W-1:0]  dly_cfg,
  output logic [NUM_CH-1:0] gate_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;
  state_t           r_state [NUM_CH];
  state_t           w_nxt   [NUM_CH];
  logic [CNT_W-1:0] r_cnt   [NUM_CH];
  logic [CNT_W-1:0] w_cnt   [NUM_CH];
  logic [CNT_W-1:0] r_len   [NUM_CH];
  logic [CNT_W-1:0] w_len   [NUM_CH];
  logic [CNT_W-1:0] r_len_cfg;
  logic [CNT_W-1:0] r_dly_cfg;
  logic [NUM_CH-1:0] w_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_cfg <= CNT_W'(DEFAULT_LEN);
      r_dly_cfg <= CNT_W'(DEFAULT_DLY);
      gate_out  <= '0;
      done      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= IDLE;
        r_cnt[c]   <= '0;
        r_len[c]   <= '0;
      end
    end else begin
      if (cfg_load) begin
        r_len_cfg <= len_cfg;
        r_dly_cfg <= dly_cfg;
      end
      done <= w_done;
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]  <= w_nxt[c];
        r_cnt[c]    <= w_cnt[c];
        r_len[c]    <= w_len[c];
        gate_out[c] <= w_nxt[c] == ACTIVE;
      end
    end
  end
  // Per-channel next state; the length is snapshotted at acceptance so later loads do not disturb it.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_nxt[c]  = r_state[c];
      w_cnt[c]  = r_cnt[c];
      w_len[c]  = r_len[c];
      w_done[c] = 1'b0;
      busy[c]   = r_state[c] != IDLE;
      case (r_state[c])
        IDLE: if (trig[c]) begin
          w_len[c]  = r_len_cfg;
          w_nxt[c]  = r_dly_cfg != '0 ? DELAY : r_len_cfg != '0 ? ACTIVE : IDLE;
          w_cnt[c]  = r_dly_cfg != '0 ? r_dly_cfg : r_len_cfg;
          w_done[c] = r_dly_cfg == '0 && r_len_cfg == '0;
        end
        DELAY: begin
          w_cnt[c] = r_cnt[c] == CNT_W'(1) ? r_len[c] : r_cnt[c] - 1'b1;
          if (r_cnt[c] == CNT_W'(1)) begin
            w_nxt[c]  = r_len[c] != '0 ? ACTIVE : IDLE;
            w_done[c] = r_len[c] == '0;
          end
        end
        ACTIVE: begin
          w_cnt[c]  = r_cnt[c] - 1'b1;
          w_nxt[c]  = r_cnt[c] == CNT_W'(1) ? IDLE : ACTIVE;
          w_done[c] = r_cnt[c] == CNT_W'(1);
`ifdef BEAM_GATE_RETRIG_EN
          // Retrigger uses the live config, not the snapshot; zero length ends the gate now.
          if (trig[c]) begin
            w_cnt[c]  = r_len_cfg;
            w_nxt[c]  = r_len_cfg != '0 ? ACTIVE : IDLE;
            w_done[c] = r_len_cfg == '0;
          end
`endif
        end
        default: w_nxt[c] = IDLE;
      endcase
    end
  end
endmodule
